cyq_seg_scan: RTL and testbench

Time-multiplexed N-digit BCD seven-segment display driver, the parametrised successor to the single-digit 4511-style decoder. It latches a packed BCD word and scans one digit per scan slot. It drives a shared active-high segment bus plus active-low one-hot digit enables. It keeps the LE/BI/LT control semantics of the single-digit decoder and adds a prescaler, digit scanning, a frame strobe and optional leading-zero blanking. It sits between the datapath (counters, adders, converters) and the board's common-cathode multi-digit display.

---
 rtl/cyq_seg_scan.sv | 136 +++++++++++++
 tb/tb_cyq_seg_scan.sv | 121 ++++++++++++
 2 files changed

// File: rtl/cyq_seg_scan.sv
// Time-multiplexed N-digit BCD seven-segment scanner with LE/BI/LT control.
// Define CYQ_SEG_SCAN_LZB_EN to blank leading zeros on digits above digit 0.
module cyq_seg_scan #(
  parameter int DIGITS   = 4,
  parameter int SCAN_DIV = 1000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  le,
  input  logic                  bi_n,
  input  logic                  lt_n,
  input  logic [4*DIGITS-1:0]   d,
  output logic [6:0]            seg,
  output logic [DIGITS-1:0]     dig_n,
  output logic                  frame
);

  localparam int IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int PW = $clog2(SCAN_DIV);
  localparam logic [IW-1:0] IDX_LAST  = IW'(DIGITS - 1);
  localparam logic [PW-1:0] PCNT_LAST = PW'(SCAN_DIV - 1);

  function automatic logic [6:0] decode(input logic [3:0] bcd);
    logic [6:0] s;
    case (bcd)
      4'd0:    s = 7'b111_1110;
      4'd1:    s = 7'b011_0000;
      4'd2:    s = 7'b110_1101;
      4'd3:    s = 7'b111_1001;
      4'd4:    s = 7'b011_0011;
      4'd5:    s = 7'b101_1011;
      4'd6:    s = 7'b101_1111;
      4'd7:    s = 7'b111_0000;
      4'd8:    s = 7'b111_1111;
      4'd9:    s = 7'b111_1011;
      default: s = 7'b000_0000;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] digit_at(input logic [4*DIGITS-1:0] q, input logic [IW-1:0] i);
    logic [3:0] r;
    r = 4'd0;
    for (int k = 0; k < DIGITS; k++) begin
      r = (IW'(k) == i) ? q[4*k +: 4] : r;
    end
    return r;
  endfunction

  function automatic logic [DIGITS-1:0] one_hot(input logic [IW-1:0] i);
    logic [DIGITS-1:0] oh;
    for (int k = 0; k < DIGITS; k++) begin
      oh[k] = (IW'(k) == i);
    end
    return oh;
  endfunction

`ifdef CYQ_SEG_SCAN_LZB_EN
  // A digit is a leading zero when it and every more significant digit are zero.
  function automatic logic lz_blank(input logic [4*DIGITS-1:0] q, input logic [IW-1:0] i);
    logic z;
    z = 1'b1;
    for (int k = 0; k < DIGITS; k++) begin
      z = ((IW'(k) >= i) && (q[4*k +: 4] != 4'd0)) ? 1'b0 : z;
    end
    return z && (i != {IW{1'b0}});
  endfunction
`endif

  logic [4*DIGITS-1:0] q_d_r;
  logic [PW-1:0]       pcnt_r;
  logic [IW-1:0]       idx_r;
  logic                tick_s;
  logic [6:0]          seg_nxt_s;
  logic [DIGITS-1:0]   dig_nxt_s;

  // Next output pattern from the current scan position and latched data.
  always_comb begin
    tick_s    = (pcnt_r == PCNT_LAST);
    seg_nxt_s = 7'b000_0000;
    dig_nxt_s = {DIGITS{1'b1}};
    if (!lt_n) begin
      seg_nxt_s = 7'b111_1111;
      dig_nxt_s = ~one_hot(idx_r);
    end else if (!bi_n) begin
      seg_nxt_s = 7'b000_0000;
      dig_nxt_s = {DIGITS{1'b1}};
    end else begin
      dig_nxt_s = ~one_hot(idx_r);
`ifdef CYQ_SEG_SCAN_LZB_EN
      if (lz_blank(q_d_r, idx_r)) begin
        seg_nxt_s = 7'b000_0000;
      end else begin
        seg_nxt_s = decode(digit_at(q_d_r, idx_r));
      end
`else
      seg_nxt_s = decode(digit_at(q_d_r, idx_r));
`endif
    end
  end

  // Data latch, prescaler, digit scan, frame strobe and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_d_r  <= {(4*DIGITS){1'b0}};
      pcnt_r <= {PW{1'b0}};
      idx_r  <= {IW{1'b0}};
      frame  <= 1'b0;
      seg    <= 7'b000_0000;
      dig_n  <= {DIGITS{1'b1}};
    end else begin
      if (!le) begin
        q_d_r <= d;
      end else begin
        q_d_r <= q_d_r;
      end
      if (tick_s) begin
        pcnt_r <= {PW{1'b0}};
        if (idx_r == IDX_LAST) begin
          idx_r <= {IW{1'b0}};
          frame <= 1'b1;
        end else begin
          idx_r <= idx_r + IW'(1);
          frame <= 1'b0;
        end
      end else begin
        pcnt_r <= pcnt_r + PW'(1);
        idx_r  <= idx_r;
        frame  <= 1'b0;
      end
      seg   <= seg_nxt_s;
      dig_n <= dig_nxt_s;
    end
  end

endmodule

// File: tb/tb_cyq_seg_scan.sv
// Randomized and directed bench for cyq_seg_scan against a cycle-count reference model.
module tb_cyq_seg_scan;
  localparam int DIGITS   = 4;
  localparam int SCAN_DIV = 4;

  logic        clk = 1'b0;
  logic        rst, le, bi_n, lt_n;
  logic [15:0] d;
  logic [6:0]  seg;
  logic [3:0]  dig_n;
  logic        frame;

  int          n_chk  = 0;
  int          n_pass = 0;
  int          k_edges;      // edges since reset release
  logic [15:0] q_model;
  logic [6:0]  dec_tab [16];

  cyq_seg_scan #(.DIGITS(DIGITS), .SCAN_DIV(SCAN_DIV)) dut (
    .clk(clk), .rst(rst), .le(le), .bi_n(bi_n), .lt_n(lt_n),
    .d(d), .seg(seg), .dig_n(dig_n), .frame(frame)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (edge %0d)", tag, got, exp, k_edges);
  endtask

  function automatic logic [6:0] model_digit_seg(input int i, input logic [15:0] q);
    logic [3:0] v;
    v = 4'((q >> (4 * i)) & 16'hF);
`ifdef CYQ_SEG_SCAN_LZB_EN
    if (i > 0 && (q >> (4 * i)) == 16'h0) return 7'b000_0000;
`endif
    return dec_tab[v];
  endfunction

  // One clock: predict, step, compare, then advance the model.
  task automatic cycle();
    logic [6:0] es;
    logic [3:0] ed;
    logic       ef;
    int         idx;
    idx = (k_edges / SCAN_DIV) % DIGITS;
    if (rst) begin
      es = 7'b0; ed = 4'b1111; ef = 1'b0;
    end else begin
      ef = ((k_edges + 1) % (SCAN_DIV * DIGITS)) == 0;
      if (!lt_n) begin
        es = 7'b111_1111; ed = ~(4'b0001 << idx);
      end else if (!bi_n) begin
        es = 7'b0; ed = 4'b1111;
      end else begin
        es = model_digit_seg(idx, q_model); ed = ~(4'b0001 << idx);
      end
    end
    @(posedge clk);
    #1;
    chk("seg", 32'(seg), 32'(es));
    chk("dig_n", 32'(dig_n), 32'(ed));
    chk("frame", 32'(frame), 32'(ef));
    if (rst) begin
      k_edges = 0; q_model = 16'h0;
    end else begin
      k_edges++;
      if (!le) q_model = d;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  initial begin
    dec_tab[0] = 7'b111_1110; dec_tab[1] = 7'b011_0000; dec_tab[2] = 7'b110_1101;
    dec_tab[3] = 7'b111_1001; dec_tab[4] = 7'b011_0011; dec_tab[5] = 7'b101_1011;
    dec_tab[6] = 7'b101_1111; dec_tab[7] = 7'b111_0000; dec_tab[8] = 7'b111_1111;
    dec_tab[9] = 7'b111_1011;
    for (int i = 10; i < 16; i++) dec_tab[i] = 7'b000_0000;
    k_edges = 0; q_model = 16'h0;
    rst = 1'b1; le = 1'b1; bi_n = 1'b1; lt_n = 1'b1; d = 16'h0;

    run(3);
    rst = 1'b0;
    cycle();
    chk("first_dig_after_reset", 32'(dig_n), 32'(4'b1110));

    d = 16'h1234; le = 1'b0; run(40);
    le = 1'b1; d = 16'h9999; run(20);
    le = 1'b0; run(20);
    lt_n = 1'b0; bi_n = 1'b0; run(8);
    lt_n = 1'b1; run(8);
    bi_n = 1'b1;
    d = 16'h0050; run(20);
    d = 16'h000A; run(10);

    for (int i = 0; i < 16 && ((k_edges / SCAN_DIV) % DIGITS) != 2; i++) cycle();
    chk("at_idx2_before_rst", 32'((k_edges / SCAN_DIV) % DIGITS), 32'd2);
    rst = 1'b1; cycle();
    rst = 1'b0; cycle();
    chk("restart_dig", 32'(dig_n), 32'(4'b1110));

    for (int i = 0; i < 2000; i++) begin
      if ($urandom_range(0, 3) == 0) begin
        for (int j = 0; j < DIGITS; j++)
          d[4*j +: 4] = ($urandom_range(0, 2) == 0) ? 4'd0 : 4'($urandom_range(0, 15));
      end
      le   = ($urandom_range(0, 3) == 0);
      lt_n = ($urandom_range(0, 15) != 0);
      bi_n = ($urandom_range(0, 15) != 0);
      rst  = ($urandom_range(0, 199) == 0);
      cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
